// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scanner with blanking gaps and frame-aligned value commit.
// Optional macro LEAD_ZERO_BLANK_EN blanks digits above the most-significant non-zero nibble.
module hex_to_7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb
      case (hex)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0011000;
         default: seg = 7'h7F;
      endcase
endmodule

module seg_scan_ctrl #(
   parameter int N_DIGITS  = 4,
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [4*N_DIGITS-1:0] wr_data,
   output logic [6:0]            seg_n,
   output logic [N_DIGITS-1:0]   dig_n,
   output logic                  frame_tick
);
   localparam int CW = $clog2(DIV > BLANK_CYC ? DIV : BLANK_CYC) + 1;
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [0:0] BLANK = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;

   logic [0:0]            state, state_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [IW-1:0]         idx, idx_nx;
   logic [4*N_DIGITS-1:0] active, pending;
   logic                  pend_flag, blank_end, drive_end, boundary, accept, commit, hide;
   logic [3:0]            nib;
   logic [6:0]            dec;

   assign blank_end = state == BLANK && cnt == CW'(BLANK_CYC - 1);
   assign drive_end = state == DRIVE && cnt == CW'(DIV - 1);
   assign boundary  = enable && drive_end && idx == IW'(N_DIGITS - 1);
   assign accept    = wr_valid && wr_ready;
   // While dark there is no frame to protect, so a pending value commits immediately.
   assign commit    = pend_flag && (boundary || !enable);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      idx_nx   = idx;
      if (!enable) begin
         state_nx = BLANK;
         cnt_nx   = '0;
         idx_nx   = '0;
      end else if (blank_end) begin
         state_nx = DRIVE;
         cnt_nx   = '0;
      end else if (drive_end) begin
         state_nx = BLANK;
         cnt_nx   = '0;
         idx_nx   = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
      end
   end

   // Outputs are registered from the next state, so the decoder looks at the upcoming digit.
   assign nib = active[{idx_nx, 2'b00} +: 4];

   hex_to_7seg u_dec (.hex(nib), .seg(dec));

`ifdef LEAD_ZERO_BLANK_EN
   logic [IW-1:0] msd;
   always_comb begin
      msd = '0;
      for (int k = 1; k < N_DIGITS; k++)
         if (active[4*k +: 4] != 4'd0) msd = IW'(k);
   end
   assign hide = idx_nx > msd;
`else
   assign hide = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= '0;
         active     <= '0;
         pending    <= '0;
         pend_flag  <= 1'b0;
         wr_ready   <= 1'b1;
         seg_n      <= 7'h7F;
         dig_n      <= '1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         dig_n      <= state_nx == DRIVE ? ~(N_DIGITS'(1) << idx_nx) : '1;
         seg_n      <= state_nx == DRIVE && !hide && nib <= 4'd9 ? dec : 7'h7F;
         frame_tick <= boundary;
         wr_ready   <= !accept && !pend_flag;
         if (accept) begin
            pending   <= wr_data;
            pend_flag <= 1'b1;
         end else if (commit) begin
            active    <= pending;
            pend_flag <= 1'b0;
         end
      end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: vector table, directed corner sequences and random traffic against a
// position-in-frame reference model.
module tb_seg_scan_ctrl;
   localparam int N = 4, DIV = 4, BLANK = 2, SLOT = BLANK + DIV, FRAME = N * SLOT;

   logic        clk = 0, rst_n = 1, enable = 1, wr_valid = 0;
   logic [15:0] wr_data = '0;
   logic        wr_ready, frame_tick;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   int          checks = 0, errors = 0;

   seg_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .seg_n(seg_n), .dig_n(dig_n), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
   int          s;
   logic [15:0] m_active, m_pend;
   bit          m_pflag, m_ready, m_tick;
   logic [6:0]  m_seg;
   logic [3:0]  m_dig;

   typedef struct {
      logic [15:0] val;
      logic [6:0]  exp [4];
   } vec_t;
   vec_t vecs [3];

   function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   function automatic logic [6:0] digit_seg(logic [15:0] v, int d);
      logic [3:0] nib;
      int msd;
      nib = v[4*d +: 4];
      msd = 0;
      for (int k = 1; k < N; k++) if (v[4*k +: 4] != 0) msd = k;
      if (nib > 9) return 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
      if (d > msd) return 7'h7F;
`endif
      return seg_tab[nib];
   endfunction

   task automatic m_reset();
      s = 0; m_active = '0; m_pend = '0; m_pflag = 0; m_ready = 1; m_tick = 0;
      m_seg = 7'h7F; m_dig = 4'hF;
   endtask

   // Scan position is just the number of enabled edges since the last restart.
   task automatic model_edge();
      bit acc, commit, pend_after;
      int p;
      acc = wr_valid && m_ready;
      s = enable ? s + 1 : 0;
      m_tick = enable && (s % FRAME == 0);
      commit = m_pflag && (m_tick || !enable);
      pend_after = acc || (m_pflag && !commit);
      m_ready = !pend_after && !commit;
      if (acc) begin m_pend = wr_data; m_pflag = 1; end
      else if (commit) begin m_active = m_pend; m_pflag = 0; end
      p = s % FRAME;
      if (enable && p % SLOT >= BLANK) begin
         m_dig = ~(4'b1 << (p / SLOT));
         m_seg = digit_seg(m_active, p / SLOT);
      end else begin
         m_dig = 4'hF; m_seg = 7'h7F;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk); #1;
      chk("seg_n", {9'd0, seg_n}, {9'd0, m_seg});
      chk("dig_n", {12'd0, dig_n}, {12'd0, m_dig});
      chk("wr_ready", {15'd0, wr_ready}, {15'd0, m_ready});
      chk("frame_tick", {15'd0, frame_tick}, {15'd0, m_tick});
   endtask

   task automatic write(input logic [15:0] v);
      wr_valid = 1; wr_data = v;
      for (int i = 0; i < 3 * FRAME; i++) begin
         bit r;
         r = wr_ready;
         tick();
         if (r) begin wr_valid = 0; return; end
      end
      wr_valid = 0; errors++;
      $display("FAIL accept_timeout value %h never accepted", v);
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (frame_tick) return;
      end
      errors++;
      $display("FAIL frame_tick_timeout no frame boundary seen");
   endtask

   task automatic wait_dig(input logic [3:0] d);
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (dig_n == d) return;
         tick();
      end
      errors++;
      $display("FAIL dig_timeout dig_n %b never seen", d);
   endtask

   initial begin
      logic [6:0] cap [4];
      vecs[0].val = 16'h1234; vecs[0].exp = '{7'h19, 7'h30, 7'h24, 7'h79};
      vecs[1].val = 16'hA0F9; vecs[1].exp = '{7'h18, 7'h7F, 7'h40, 7'h7F};
      vecs[2].val = 16'h0007;
`ifdef LEAD_ZERO_BLANK_EN
      vecs[2].exp = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
`else
      vecs[2].exp = '{7'h78, 7'h40, 7'h40, 7'h40};
`endif
      #1 rst_n = 0;
      #1;
      chk("rst_seg", {9'd0, seg_n}, 16'h7F);
      chk("rst_dig", {12'd0, dig_n}, 16'hF);
      chk("rst_ready", {15'd0, wr_ready}, 16'h1);
      chk("rst_tick", {15'd0, frame_tick}, 16'h0);
      m_reset();
      @(negedge clk) rst_n = 1;
      tick(); tick();
      chk("first_drive", {12'd0, dig_n}, 16'hE);

      for (int v = 0; v < 3; v++) begin
         write(vecs[v].val);
         wait_tick();
         cap = '{7'h55, 7'h55, 7'h55, 7'h55};
         for (int i = 0; i < FRAME; i++) begin
            tick();
            for (int d = 0; d < N; d++) if (!dig_n[d]) cap[d] = seg_n;
         end
         for (int d = 0; d < N; d++) chk($sformatf("vec%0d_digit%0d", v, d), {9'd0, cap[d]}, {9'd0, vecs[v].exp[d]});
      end

      wr_valid = 1; wr_data = 16'h1111;
      write(16'h1111);
      wr_valid = 1; wr_data = 16'h2222;
      tick();
      chk("b2b_ready_low", {15'd0, wr_ready}, 16'h0);
      write(16'h2222);
      repeat (2 * FRAME) tick();

      wait_dig(4'b1011);
      enable = 0;
      tick();
      chk("dis_dig", {12'd0, dig_n}, 16'hF);
      chk("dis_seg", {9'd0, seg_n}, 16'h7F);
      write(16'h5678);
      repeat (3) tick();
      enable = 1;
      tick(); tick();
      chk("reen_drive", {12'd0, dig_n}, 16'hE);
      repeat (FRAME) tick();

      wait_dig(4'b1101);
      #3 rst_n = 0;
      #1;
      chk("arst_seg", {9'd0, seg_n}, 16'h7F);
      chk("arst_dig", {12'd0, dig_n}, 16'hF);
      chk("arst_ready", {15'd0, wr_ready}, 16'h1);
      m_reset();
      @(negedge clk) rst_n = 1;
      repeat (FRAME) tick();

      for (int i = 0; i < 1500; i++) begin
         enable = $urandom_range(0, 24) != 0;
         if (!(wr_valid && !wr_ready)) begin
            wr_valid = $urandom_range(0, 2) == 0;
            wr_data = 16'($urandom);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits. A single shared hex_to_7seg decoder drives all digits. The block holds a multi-digit value loaded through a valid/ready handshake and walks the digit enables one slot at a time. A blanking gap between slots suppresses ghosting. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
N_DIGITS, 4, number of digits scanned (>=2)
DIV, 50000, clk cycles each digit is driven per slot (>=1)
BLANK_CYC, 16, clk cycles of all-off blanking before each digit slot (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; 0 forces display dark
wr_valid  in  1  write request
wr_ready  out  1  write accept
wr_data  in  4*N_DIGITS  value; nibble k -> digit k (digit 0 = wr_data[3:0])
seg_n  out  7  low-active segments, bit order as hex_to_7seg
dig_n  out  N_DIGITS  low-active digit enables, at most one low
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, any state, including mid-DRIVE): seg_n=7'h7F, dig_n=all 1, wr_ready=1, frame_tick=0.
- Reset also clears: active and pending registers = 0, pend_flag=0, idx=0, cnt=0, state=BLANK.
- All outputs are registered and update on the same edge as the state. dig_n is low for exactly DIV consecutive cycles per slot.
- FSM, BLANK state: dig_n all 1, seg_n=7'h7F. cnt runs 0..BLANK_CYC-1; on the terminal count go to DRIVE with cnt=0.
- FSM, DRIVE state: dig_n[idx]=0 and seg_n=decode(active nibble idx). cnt runs 0..DIV-1; on the terminal count go to BLANK, cnt=0, idx=idx+1 with wrap N_DIGITS-1 -> 0.
- Frame boundary: the edge leaving DRIVE with idx=N_DIGITS-1. On that edge frame_tick=1 for one cycle. If pend_flag=1, then active<=pending and pend_flag<=0 on the same edge.
- Frame length: N_DIGITS*(BLANK_CYC+DIV) cycles.
- Decode: uses the shared hex_to_7seg instance, which defines codes 0-9 only. For a nibble >9 the controller forces seg_n=7'h7F; digit enable timing is unchanged.
- Handshake: transfer occurs when wr_valid & wr_ready. Accepted data goes to pending, pend_flag<=1, wr_ready<=0 from the next cycle. wr_ready returns to 1 the cycle after commit.
- The source holds wr_data stable while wr_valid=1 and wr_ready=0.
- Data accepted on a frame-boundary edge is not committed on that edge; it waits for the next boundary.
- enable=0: next edge goes to state=BLANK, idx=0, cnt=0, outputs dark, no frame_tick.
- While enable=0 the handshake still operates. A pending value commits on the edge after acceptance, so wr_ready returns to 1 two cycles after acceptance.
- enable 0->1: scan restarts at the BLANK of digit 0.
- Counter widths are $clog2 of the max of DIV and BLANK_CYC, plus 1. The idx width is $clog2(N_DIGITS).

Optional Feature:
Macro LEAD_ZERO_BLANK_EN.
- Defined: every digit above the most-significant non-zero nibble of active shows seg_n=7'h7F. Slot timing and dig_n are unchanged. Digit 0 is always displayed, so value 0 shows a single "0".
- Undefined: all digits are decoded, and leading zeros show 7'b1000000.

Test Plan:
All scenarios use N_DIGITS=4, DIV=4, BLANK_CYC=2 (frame = 24 cycles).
- Reset assert -> seg_n=7'h7F, dig_n=4'hF, wr_ready=1, frame_tick=0; first DRIVE of digit 0 starts 2 cycles after rst_n release, dig_n=4'b1110 for 4 cycles.
- Write 16'h1234 -> commit at the next frame_tick. Next frame shows, per digit:
  - dig_n=1110: seg_n=7'b0011001
  - dig_n=1101: seg_n=7'b0110000
  - dig_n=1011: seg_n=7'b0100100
  - dig_n=0111: seg_n=7'b1111001
- Write 16'hA0F9 -> digits 1 and 3 show seg_n=7'h7F with dig_n still asserted. Digit 0 shows 7'b0011000 and digit 2 shows 7'b1000000.
- Back-to-back writes 16'h1111 then 16'h2222 with wr_valid held -> wr_ready=0 after the first accept. Second accept occurs the cycle after wr_ready returns to 1 (post-commit), and it displays one frame later.
- enable=0 mid-DRIVE of digit 2 -> next cycle dig_n=4'hF, seg_n=7'h7F. After re-enable, digit 0 drives after 2 blank cycles. An async rst_n pulse mid-DRIVE blanks outputs immediately.
- Write 16'h0007 -> with LEAD_ZERO_BLANK_EN, digits 3..1 show 7'h7F and digit 0 shows 7'b1111000. Without the macro, digits 3..1 show 7'b1000000.
